// File: rtl/pc_seq_monitor_if.sv
// Bus between a PC source/config host and pc_seq_monitor.
// The host drives samples, config and clear. The monitor returns count, match and overflow.
interface pc_seq_monitor_if #(
  parameter int ADDR_W  = 32,
  parameter int SEQ_LEN = 3,
  parameter int CNT_W   = 5
);
  localparam int IDX_W = $clog2(SEQ_LEN);
  localparam int LEN_W = $clog2(SEQ_LEN + 1);

  logic [ADDR_W-1:0] pc_add;
  logic              enable;
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [ADDR_W-1:0] cfg_data;
  logic [LEN_W-1:0]  cfg_len;
  logic              clear;
  logic [CNT_W-1:0]  count;
  logic              match;
  logic              overflow;

  modport master (
    output pc_add, enable, cfg_we, cfg_idx, cfg_data, cfg_len, clear,
    input  count, match, overflow
  );

  modport slave (
    input  pc_add, enable, cfg_we, cfg_idx, cfg_data, cfg_len, clear,
    output count, match, overflow
  );
endinterface

// File: rtl/pc_seq_monitor.sv
// Programmable PC-sequence monitor. It matches up to SEQ_LEN sampled addresses, overlapping matches included.
// Each match gives a one-cycle pulse and a saturating or wrapping match count.
module pc_seq_monitor #(
  parameter int ADDR_W  = 32,
  parameter int SEQ_LEN = 3,
  parameter int CNT_W   = 5,
  parameter bit SAT     = 1'b1
)(
  input logic             clk,
  input logic             rst,
  pc_seq_monitor_if.slave bus
);
  localparam int IDX_W = $clog2(SEQ_LEN);
  localparam int LEN_W = $clog2(SEQ_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SEQ_LEN-1:0][ADDR_W-1:0] hist, pat;
  logic [LEN_W-1:0]               fill, len;
  logic [CNT_W-1:0]               count;
  logic                           match, overflow, hit;
  logic                           len_ok, idx_ok;

  // hist[0] is the newest sample. It lines up against pat[len-2]. pc_add lines up against pat[len-1].
  always_comb begin
    hit = bus.enable && !bus.cfg_we &&
          (int'(fill) >= int'(len) - 1) &&
          (bus.pc_add == pat[IDX_W'(int'(len) - 1)]);
    for (int k = 0; k < SEQ_LEN - 1; k++)
      if ((k <= int'(len) - 2) && (hist[k] != pat[IDX_W'(int'(len) - 2 - k)]))
        hit = 1'b0;
  end

  assign len_ok = (bus.cfg_len != '0) && (int'(bus.cfg_len) <= SEQ_LEN);
  assign idx_ok = int'(bus.cfg_idx) < SEQ_LEN;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist     <= '0;
      pat      <= '0;
      fill     <= '0;
      len      <= LEN_W'(SEQ_LEN);
      count    <= '0;
      match    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      match <= hit;
      // A config write flushes the history. A sample taken in the same cycle is dropped.
      if (bus.cfg_we) begin
        if (idx_ok) pat[bus.cfg_idx] <= bus.cfg_data;
        if (len_ok) len <= bus.cfg_len;
        hist <= '0;
        fill <= '0;
      end else if (bus.enable) begin
        hist <= {hist[SEQ_LEN-2:0], bus.pc_add};
        if (int'(fill) < SEQ_LEN) fill <= fill + 1'b1;
      end
      if (bus.clear) begin
        count    <= '0;
        overflow <= 1'b0;
      end else if (hit) begin
        if (count == CNT_MAX) begin
          overflow <= 1'b1;
          if (!SAT) count <= '0;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

  assign bus.count    = count;
  assign bus.match    = match;
  assign bus.overflow = overflow;
endmodule

// File: tb/tb_pc_seq_monitor.sv
// Directed bench for pc_seq_monitor. It runs a saturating and a wrapping instance side by side on the same stimulus.
module tb_pc_seq_monitor;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_add = '0, cfg_data = '0;
  logic        enable = 1'b0, cfg_we = 1'b0, clear = 1'b0;
  logic [1:0]  cfg_idx = '0, cfg_len = '0;
  int          checks = 0, failures = 0, pulses = 0;

  pc_seq_monitor_if #(.ADDR_W(32), .SEQ_LEN(3), .CNT_W(5)) if_s ();
  pc_seq_monitor_if #(.ADDR_W(32), .SEQ_LEN(3), .CNT_W(5)) if_w ();

  assign if_s.pc_add = pc_add;   assign if_w.pc_add = pc_add;
  assign if_s.enable = enable;   assign if_w.enable = enable;
  assign if_s.cfg_we = cfg_we;   assign if_w.cfg_we = cfg_we;
  assign if_s.cfg_idx = cfg_idx; assign if_w.cfg_idx = cfg_idx;
  assign if_s.cfg_data = cfg_data; assign if_w.cfg_data = cfg_data;
  assign if_s.cfg_len = cfg_len; assign if_w.cfg_len = cfg_len;
  assign if_s.clear = clear;     assign if_w.clear = clear;

  pc_seq_monitor #(.ADDR_W(32), .SEQ_LEN(3), .CNT_W(5), .SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .bus(if_s));
  pc_seq_monitor #(.ADDR_W(32), .SEQ_LEN(3), .CNT_W(5), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .bus(if_w));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge. Outputs are read 1ns after the rising edge.
  task automatic drive(input int pc, input int en, input int we, input int idx,
                       input int data, input int len, input int clr);
    @(negedge clk);
    pc_add   = 32'(pc);
    enable   = (en != 0);
    cfg_we   = (we != 0);
    cfg_idx  = 2'(idx);
    cfg_data = 32'(data);
    cfg_len  = 2'(len);
    clear    = (clr != 0);
    @(posedge clk);
    #1;
    if (if_s.match) pulses++;
  endtask

  task automatic smp(input int pc, input int en);
    drive(pc, en, 0, 0, 0, 0, 0);
  endtask

  task automatic cfg(input int idx, input int data, input int len);
    drive(0, 0, 1, idx, data, len, 0);
  endtask

  task automatic clr();
    drive(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic prog3();
    cfg(0, 17, 3); cfg(1, 27, 3); cfg(2, 20, 3);
  endtask

  initial begin
    #12;
    chk("rst_count", 32'(if_s.count), 0);
    chk("rst_match", 32'(if_s.match), 0);
    chk("rst_ovf", 32'(if_s.overflow), 0);
    @(negedge clk);
    rst = 1'b1;

    // 28 matches stay below either counter limit
    prog3();
    pulses = 0;
    for (int i = 0; i < 28; i++) begin
      smp(17, 1); smp(27, 1); smp(20, 1);
      if (i == 0) chk("t1_pulse", 32'(if_s.match), 1);
      smp(0, 1);
      if (i == 0) chk("t1_pulse_drop", 32'(if_s.match), 0);
    end
    chk("t1_pulses", 32'(pulses), 28);
    chk("t1_cnt_sat", 32'(if_s.count), 28);
    chk("t1_cnt_wrap", 32'(if_w.count), 28);
    chk("t1_ovf_sat", 32'(if_s.overflow), 0);
    chk("t1_ovf_wrap", 32'(if_w.overflow), 0);
    clr();
    chk("clr_cnt", 32'(if_s.count), 0);

    // 40 matches: the saturating counter holds at 31, the wrapping counter reaches 40 mod 32 = 8
    for (int i = 0; i < 40; i++) begin
      smp(17, 1); smp(27, 1); smp(20, 1); smp(0, 1);
    end
    chk("t2_cnt_sat", 32'(if_s.count), 31);
    chk("t2_ovf_sat", 32'(if_s.overflow), 1);
    chk("t2_cnt_wrap", 32'(if_w.count), 8);
    chk("t2_ovf_wrap", 32'(if_w.overflow), 1);
    clr();
    chk("t2_ovf_clr", 32'(if_w.overflow), 0);

    // len=2 pattern with overlapping matches
    cfg(0, 5, 2); cfg(1, 5, 2);
    smp(5, 1); chk("t3_first", 32'(if_s.match), 0);
    smp(5, 1); chk("t3_second", 32'(if_s.match), 1);
    smp(5, 1); chk("t3_third", 32'(if_s.match), 1);
    chk("t3_cnt", 32'(if_s.count), 2);

    // a sample with enable low is ignored, and the gap does not break the sequence
    clr(); prog3();
    smp(17, 1); smp(27, 0); smp(27, 1); smp(20, 1);
    chk("t4_match", 32'(if_s.match), 1);
    chk("t4_cnt", 32'(if_s.count), 1);
    smp(17, 1); smp(27, 1); smp(99, 0); smp(20, 1);
    chk("t4_gap_match", 32'(if_s.match), 1);
    chk("t4_gap_cnt", 32'(if_s.count), 2);

    // a config write flushes the history and wins over a sample in the same cycle
    clr();
    smp(17, 1); smp(27, 1);
    drive(20, 1, 1, 2, 20, 3, 0);
    chk("t5_cfg_vs_en", 32'(if_s.match), 0);
    smp(20, 1);
    chk("t5_flushed", 32'(if_s.match), 0);
    chk("t5_cnt0", 32'(if_s.count), 0);
    smp(17, 1); smp(27, 1); smp(20, 1);
    chk("t5_cnt1", 32'(if_s.count), 1);
    smp(17, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t5_async_cnt", 32'(if_s.count), 0);
    chk("t5_async_match", 32'(if_s.match), 0);
    @(negedge clk);
    rst = 1'b1;
    // cfg_len=0 is invalid, so len must still hold its reset value of 3
    cfg(0, 17, 0); cfg(1, 27, 0); cfg(2, 20, 0);
    smp(27, 1); smp(20, 1);
    chk("t5_short", 32'(if_s.match), 0);
    smp(17, 1); smp(27, 1); smp(20, 1);
    chk("t5_rst_len", 32'(if_s.match), 1);

    // clear in the same cycle as a match
    clr();
    for (int i = 0; i < 9; i++) begin
      smp(17, 1); smp(27, 1); smp(20, 1);
    end
    chk("t6_cnt9", 32'(if_s.count), 9);
    smp(17, 1); smp(27, 1);
    drive(20, 1, 0, 0, 0, 0, 1);
    chk("t6_clr_cnt", 32'(if_s.count), 0);
    chk("t6_clr_match", 32'(if_s.match), 1);
    chk("t6_clr_ovf", 32'(if_s.overflow), 0);
    // a write to out-of-range slot 3 with invalid len 0 leaves the pattern and len unchanged
    cfg(3, 99, 0);
    smp(17, 1); smp(27, 1); smp(20, 1);
    chk("t6_len_kept", 32'(if_s.match), 1);
    chk("t6_cnt1", 32'(if_s.count), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
